// File: rtl/switch_led_groups_sync_if.sv
// Board-facing signal bundle for the switch/LED driver: raw switches and
// buttons in, registered LED drive out. Clock and reset stay plain ports.
interface switch_led_groups_sync_if #(
    parameter int NUM_GROUPS = 4,
    parameter int GROUP_W    = 4
);
    localparam int N = NUM_GROUPS * GROUP_W;

    logic [N-1:0]          sw;
    logic [NUM_GROUPS-1:0] btn;
    logic [N-1:0]          led;

    // Board / stimulus side drives the raw inputs and observes the LEDs
    modport master (
        output sw,
        output btn,
        input  led
    );

    // LED driver side consumes the raw inputs and drives the LEDs
    modport slave (
        input  sw,
        input  btn,
        output led
    );
endinterface

// File: rtl/switch_led_groups_sync.sv
// Registered switch-to-LED driver with per-group button blanking.
// Switches and buttons are synchronised into the clk domain; buttons are
// additionally debounced. Each debounced button blanks its GROUP_W-wide
// LED group. The LED drive comes straight from a register, so no input
// reaches the output combinationally.
// SYNC_STAGES must be at least 2 and DEBOUNCE_CYCLES at least 1.
module switch_led_groups_sync #(
    parameter int NUM_GROUPS      = 4,
    parameter int GROUP_W         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    switch_led_groups_sync_if.slave  bus
);
    localparam int N     = NUM_GROUPS * GROUP_W;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]          sw_sync  [SYNC_STAGES];
    logic [NUM_GROUPS-1:0] btn_sync [SYNC_STAGES];
    logic [N-1:0]          sw_s;
    logic [NUM_GROUPS-1:0] btn_s;

    logic [NUM_GROUPS-1:0] btn_d;
    logic [CNT_W-1:0]      cnt [NUM_GROUPS];

    logic [N-1:0]          mask;
    logic [N-1:0]          led_q;

    // Synchroniser chains for the asynchronous switches and buttons
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= '0;
                btn_sync[i] <= '0;
            end
        end else begin
            sw_sync[0]  <= bus.sw;
            btn_sync[0] <= bus.btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= sw_sync[i-1];
                btn_sync[i] <= btn_sync[i-1];
            end
        end
    end

    assign sw_s  = sw_sync[SYNC_STAGES-1];
    assign btn_s = btn_sync[SYNC_STAGES-1];

    // Per-button debouncer: accept a new level only after it has differed
    // from the accepted level for DEBOUNCE_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_d <= '0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                cnt[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (btn_s[g] == btn_d[g]) begin
                    cnt[g] <= '0;
                end else if (cnt[g] == CNT_MAX) begin
                    btn_d[g] <= btn_s[g];
                    cnt[g]   <= '0;
                end else begin
                    cnt[g] <= cnt[g] + CNT_W'(1);
                end
            end
        end
    end

    // Spread each debounced button across the LEDs of its group
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = btn_d[i / GROUP_W];
        end
    end

    // Registered LED drive: switches pass through except in blanked groups
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q <= '0;
        end else begin
            led_q <= sw_s & ~mask;
        end
    end

    assign bus.led = led_q;

endmodule

// File: tb/tb_switch_led_groups_sync.sv
// Directed self-checking bench for switch_led_groups_sync with default
// parameters: reset, passthrough latency, single/multiple group blanking,
// per-button sweep, debounce glitch rejection and mid-run reset.
module tb_switch_led_groups_sync;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    switch_led_groups_sync_if #(.NUM_GROUPS(4), .GROUP_W(4)) bus ();

    switch_led_groups_sync #(
        .NUM_GROUPS      (4),
        .GROUP_W         (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic [3:0] b);
        bus.sw  = s;
        bus.btn = b;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expected);
        total++;
        assert (bus.led === expected) else begin
            bad++;
            $error("[TB] FAIL %s: led=%h expected=%h", tag, bus.led, expected);
        end
    endtask

    // Directed test sequence; all checks sample 1 time unit after a rising edge
    initial begin
        logic [15:0] sweepExp [4];
        total = 0;
        bad   = 0;
        sweepExp[0] = 16'hFFF0;
        sweepExp[1] = 16'hFF0F;
        sweepExp[2] = 16'hF0FF;
        sweepExp[3] = 16'h0FFF;

        // Reset held for 3 edges with every input high
        rst_n = 1'b0;
        applyStimulus(16'hFFFF, 4'b1111);
        tick(1); checkOutput("reset_c1", 16'h0000);
        tick(1); checkOutput("reset_c2", 16'h0000);
        tick(1); checkOutput("reset_c3", 16'h0000);
        rst_n = 1'b1;
        tick(1); checkOutput("reset_release", 16'h0000);

        // Settle everything to zero
        applyStimulus(16'h0000, 4'b0000);
        tick(12); checkOutput("settle_zero", 16'h0000);

        // Passthrough with exact 3-edge latency
        applyStimulus(16'hA5A5, 4'b0000);
        tick(2); checkOutput("pass_a5_early", 16'h0000);
        tick(1); checkOutput("pass_a5", 16'hA5A5);
        applyStimulus(16'h0000, 4'b0000);
        tick(2); checkOutput("pass_zero_early", 16'hA5A5);
        tick(1); checkOutput("pass_zero", 16'h0000);

        // Single group blanking with exact 7-edge latency
        applyStimulus(16'hA5A5, 4'b0000);
        tick(3); checkOutput("single_base", 16'hA5A5);
        applyStimulus(16'hA5A5, 4'b0001);
        tick(6); checkOutput("grp0_early", 16'hA5A5);
        tick(1); checkOutput("grp0", 16'hA5A0);
        applyStimulus(16'hA5A5, 4'b0010);
        tick(6); checkOutput("grp1_early", 16'hA5A0);
        tick(1); checkOutput("grp1", 16'hA505);

        // Multiple groups, all groups, then release
        applyStimulus(16'hA5A5, 4'b0101);
        tick(7); checkOutput("grp0_2", 16'hA0A0);
        applyStimulus(16'hA5A5, 4'b1111);
        tick(7); checkOutput("grp_all", 16'h0000);
        applyStimulus(16'hA5A5, 4'b0000);
        tick(6); checkOutput("release_early", 16'h0000);
        tick(1); checkOutput("release", 16'hA5A5);

        // Sweep each button alone over all-ones switches
        applyStimulus(16'hFFFF, 4'b0000);
        tick(3); checkOutput("sweep_base", 16'hFFFF);
        for (int g = 0; g < 4; g++) begin
            applyStimulus(16'hFFFF, 4'(1 << g));
            tick(7); checkOutput($sformatf("sweep_press%0d", g), sweepExp[g]);
            applyStimulus(16'hFFFF, 4'b0000);
            tick(7); checkOutput($sformatf("sweep_release%0d", g), 16'hFFFF);
        end

        // Short pulses (2 and 3 cycles) on btn[3] must be rejected
        applyStimulus(16'hFFFF, 4'b1000);
        tick(2);
        applyStimulus(16'hFFFF, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick(1); checkOutput($sformatf("glitch2_c%0d", k), 16'hFFFF);
        end
        applyStimulus(16'hFFFF, 4'b1000);
        tick(3);
        applyStimulus(16'hFFFF, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick(1); checkOutput($sformatf("glitch3_c%0d", k), 16'hFFFF);
        end

        // One-cycle reset while btn[0] is held
        applyStimulus(16'hFFFF, 4'b0001);
        tick(7); checkOutput("pre_reset", 16'hFFF0);
        rst_n = 1'b0;
        tick(1); checkOutput("mid_reset", 16'h0000);
        rst_n = 1'b1;
        tick(2); checkOutput("post_reset_early", 16'h0000);
        tick(1); checkOutput("post_reset_sw", 16'hFFFF);
        tick(3); checkOutput("post_reset_btn_early", 16'hFFFF);
        tick(1); checkOutput("post_reset_btn", 16'hFFF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
